regfile_dump: RTL
=================

Name: regfile_dump

Overview:
- Debug read-out engine on the register-file read side; the counterpart to the core's write path.
- On a start pulse, it walks register addresses sequentially through one register-file read port.
- Each read value is registered and streamed out over a valid/ready interface, with index and last markers.
- Sits beside the RV32I core. It drives a spare read-address port (or the rs2 port, muxed while the core is halted) and feeds a debug/trace sink.

Parameters:
- NUM_REGS, 32, number of architectural registers walked (2..32).
- XLEN, 32, register data width.
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high; all state cleared immediately on assertion.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- busy  output  1  high from the cycle after an accepted start until the cycle DONE is left.
- done  output  1  one-cycle pulse after the last beat is accepted.
- rf_addr  output  ADDR_W  read address to the register file.
- rf_data  input  XLEN  combinational read data for rf_addr; x0 returns 0.
- out_valid  output  1  beat available.
- out_ready  input  1  sink accepts beat.
- out_data  output  XLEN  registered register value.
- out_index  output  ADDR_W  register number of the current beat.
- out_last  output  1  high with the final beat of the dump.

Behaviour:
- Reset values: busy=0, done=0, rf_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, state=IDLE, idx=first index.
- First index is 0, or 1 with the optional feature enabled.
- Each output takes its reset value immediately when rst rises, regardless of the clock.
- State machine:
  - IDLE: rf_addr=idx. start=1 → READ; idx loaded with the first index.
  - READ (1 cycle): rf_addr=idx. On the edge, out_data<=rf_data, out_index<=idx, out_last<=(idx==NUM_REGS-1), out_valid<=1; → SEND.
  - SEND: out_valid held high. out_data, out_index and out_last stay stable until handshake (out_valid & out_ready).
    - On handshake with out_last=0: out_valid<=0, idx<=idx+1, → READ.
    - On handshake with out_last=1: out_valid<=0, → DONE.
  - DONE (1 cycle): done=1; → IDLE.
- Latency:
  - start → first out_valid: 2 edges.
  - Back-to-back beats with out_ready held high: one beat every 2 cycles.
  - Full 32-register dump with ready always high: 64 cycles from start to done pulse.
- start while busy or in DONE: ignored, no queuing.
- out_ready while out_valid=0: no effect.
- Core writes during a dump: each beat reflects the register value at its own READ cycle. The dump is not atomic across registers, and no snapshot is guaranteed.
- idx never exceeds NUM_REGS-1; no wrap-around is possible.
- Reset mid-operation (any state): immediately return to IDLE with reset values. A beat in flight is discarded and no done is generated.
- busy=1 in READ, SEND and DONE; busy=0 in IDLE.

Optional Feature:
- Macro: REGFILE_DUMP_SKIP_ZERO_EN.
- Defined: x0 is skipped. First index is 1; a dump produces NUM_REGS-1 beats (31 by default); out_index runs 1..31.
- Undefined: x0 is included. First index is 0; a dump produces NUM_REGS beats, and beat 0 carries out_data=0, out_index=0.

Test Plan:
- Preload x1..x31 = 0x1000_0000+i. Pulse start with out_ready=1 → 32 beats (feature off); index 0..31; data 0, then 0x1000_0001..0x1000_001F; out_last only on index 31; done pulse at cycle 64.
- Backpressure: hold out_ready=0 for 5 cycles on beat index 3 → out_valid stays 1 and data/index stay stable (0x1000_0003, 3); stream continues after ready.
- start pulsed again at beat index 10 → ignored; exactly one done pulse; total beat count unchanged.
- Assert rst while in SEND at index 7 → out_valid, busy and out_index go to 0 before the next clock edge; no done pulse. A new start then restarts at index 0.
- Core writes x5=0xDEAD_BEEF before the READ cycle of index 5 → beat 5 carries 0xDEAD_BEEF.
- REGFILE_DUMP_SKIP_ZERO_EN defined → first beat index 1, 31 beats, out_last on index 31, done at cycle 62.

Source files
------------

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks read addresses after a start pulse and streams each value out over valid/ready.
// Defining REGFILE_DUMP_SKIP_ZERO_EN skips x0, so the walk starts at index 1.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [XLEN-1:0]   rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last
);

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
`endif
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;

    // rf_addr is a registered copy of idx; it is updated on the same edge as idx so READ always sees the right address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= FIRST_IDX;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= READ;
                        idx     <= FIRST_IDX;
                        rf_addr <= FIRST_IDX;
                        busy    <= 1'b1;
                    end else begin
                        rf_addr <= idx;
                    end
                end
                READ: begin
                    out_data  <= rf_data;
                    out_index <= idx;
                    out_last  <= (idx == LAST_IDX);
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            idx     <= idx + ADDR_W'(1);
                            rf_addr <= idx + ADDR_W'(1);
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
